// File: rtl/alu_issue_sequencer_pkg.sv
// Shared constants for the ALU issue sequencer: operand width, opcodes,
// ALU register-file indices and the sequencer state encoding.
package alu_issue_sequencer_pkg;

  localparam int OPERAND_WIDTH = 8;

  localparam logic [OPERAND_WIDTH-1:0] OP_ADD      = 8'h01;
  localparam logic [OPERAND_WIDTH-1:0] OP_SUB      = 8'h02;
  localparam logic [OPERAND_WIDTH-1:0] OP_AND      = 8'h03;
  localparam logic [OPERAND_WIDTH-1:0] OP_OR       = 8'h04;
  localparam logic [OPERAND_WIDTH-1:0] OP_XOR      = 8'h05;
  localparam logic [OPERAND_WIDTH-1:0] OP_MULTIPLY = 8'h06;
  localparam logic [OPERAND_WIDTH-1:0] OP_DIVIDE   = 8'h07;

  localparam logic [2:0] REG_OP = 3'd0;
  localparam logic [2:0] REG_A  = 3'd1;
  localparam logic [2:0] REG_B  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_A    = 3'd1,
    ST_WR_B    = 3'd2,
    ST_WR_OP   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESP    = 3'd5
  } seq_state_t;

  function automatic logic is_write_state(input seq_state_t s);
    return (s == ST_WR_A) || (s == ST_WR_B) || (s == ST_WR_OP);
  endfunction

endpackage

// File: rtl/alu_issue_sequencer_shadow_regs.sv
// Shadow copies of the three ALU registers; flags which of a new request's
// fields actually need to be written.
module alu_issue_sequencer_shadow_regs #(
  parameter int OPERAND_WIDTH  = alu_issue_sequencer_pkg::OPERAND_WIDTH,
  parameter int SKIP_REDUNDANT = 1
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     wr_en,
  input  logic [2:0]               wr_addr,
  input  logic [OPERAND_WIDTH-1:0] wr_data,
  input  logic [OPERAND_WIDTH-1:0] cmp_op,
  input  logic [OPERAND_WIDTH-1:0] cmp_a,
  input  logic [OPERAND_WIDTH-1:0] cmp_b,
  output logic                     need_op,
  output logic                     need_a,
  output logic                     need_b
);
  import alu_issue_sequencer_pkg::*;

  localparam int NUM_REGS = 3;

  logic [NUM_REGS-1:0] w_need;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_shadow
      localparam logic [2:0] IDX = 3'(gi);
      logic [OPERAND_WIDTH-1:0] r_val;
      logic                     r_vld;
      logic [OPERAND_WIDTH-1:0] w_cmp;

      assign w_cmp = (IDX == REG_OP) ? cmp_op :
                     (IDX == REG_A)  ? cmp_a  : cmp_b;

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          r_val <= '0;
          r_vld <= 1'b0;
        end else if (wr_en && (wr_addr == IDX)) begin
          r_val <= wr_data;
          r_vld <= 1'b1;
        end
      end

      // An invalid shadow always forces a write, so the ALU never starts stale.
      assign w_need[gi] = (SKIP_REDUNDANT == 0) || !r_vld || (r_val != w_cmp);
    end
  endgenerate

  assign need_op = w_need[0];
  assign need_a  = w_need[1];
  assign need_b  = w_need[2];

endmodule

// File: rtl/alu_issue_sequencer.sv
// Serialises {opcode, A, B} requests into ALU register-file writes, then
// captures the ALU result/flags and returns them on a valid/ready channel.
module alu_issue_sequencer #(
  parameter int OPERAND_WIDTH  = alu_issue_sequencer_pkg::OPERAND_WIDTH,
  parameter int SKIP_REDUNDANT = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [OPERAND_WIDTH-1:0] req_op,
  input  logic [OPERAND_WIDTH-1:0] req_a,
  input  logic [OPERAND_WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [OPERAND_WIDTH-1:0] rsp_result,
  output logic                     rsp_zero,
  output logic                     rsp_carry,
  output logic                     rsp_overflow,
  output logic                     rsp_error,
  output logic                     alu_writeEn,
  output logic [2:0]               alu_writeAddress,
  output logic [OPERAND_WIDTH-1:0] alu_inst,
  input  logic [OPERAND_WIDTH-1:0] alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_carry,
  input  logic                     alu_overflow,
  input  logic                     alu_error,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     op_count,
  output logic [7:0]               err_count
);
  import alu_issue_sequencer_pkg::*;

  seq_state_t               r_state;
  seq_state_t               w_state_next;
  seq_state_t               w_first_state;

  logic [OPERAND_WIDTH-1:0] r_op;
  logic [OPERAND_WIDTH-1:0] r_a;
  logic [OPERAND_WIDTH-1:0] r_b;
  logic                     r_need_b;
  logic                     r_need_op;

  logic                     r_write_en;
  logic [2:0]               r_write_addr;
  logic [OPERAND_WIDTH-1:0] r_inst;

  logic                     r_rsp_valid;
  logic [OPERAND_WIDTH-1:0] r_rsp_result;
  logic                     r_rsp_zero;
  logic                     r_rsp_carry;
  logic                     r_rsp_overflow;
  logic                     r_rsp_error;

  logic [CNT_WIDTH-1:0]     r_op_count;
  logic [7:0]               r_err_count;

  logic                     w_req_ready;
  logic                     w_accept;
  logic                     w_pop;
  logic                     w_need_op;
  logic                     w_need_a;
  logic                     w_need_b;
  logic [2:0]               w_wr_addr;
  logic [OPERAND_WIDTH-1:0] w_wr_data;

  // Shadows compare against the live request; the result only matters on accept.
  alu_issue_sequencer_shadow_regs #(
    .OPERAND_WIDTH  (OPERAND_WIDTH),
    .SKIP_REDUNDANT (SKIP_REDUNDANT)
  ) u_shadow (
    .clk     (clk),
    .rstN    (rstN),
    .wr_en   (r_write_en),
    .wr_addr (r_write_addr),
    .wr_data (r_inst),
    .cmp_op  (req_op),
    .cmp_a   (req_a),
    .cmp_b   (req_b),
    .need_op (w_need_op),
    .need_a  (w_need_a),
    .need_b  (w_need_b)
  );

  assign w_req_ready = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
  assign w_accept    = req_valid && w_req_ready;
  assign w_pop       = r_rsp_valid && rsp_ready;

  always_comb begin
    w_first_state = ST_CAPTURE;
    if (w_need_a)
      w_first_state = ST_WR_A;
    else if (w_need_b)
      w_first_state = ST_WR_B;
    else if (w_need_op)
      w_first_state = ST_WR_OP;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_state_next = w_first_state;
      end
      ST_WR_A: begin
        if (r_need_b)
          w_state_next = ST_WR_B;
        else if (r_need_op)
          w_state_next = ST_WR_OP;
        else
          w_state_next = ST_CAPTURE;
      end
      ST_WR_B:    w_state_next = r_need_op ? ST_WR_OP : ST_CAPTURE;
      ST_WR_OP:   w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_RESP;
      ST_RESP: begin
        if (w_accept)
          w_state_next = w_first_state;
        else if (w_pop)
          w_state_next = ST_IDLE;
      end
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // First write of a request comes straight from the ports, not the capture regs.
  always_comb begin
    w_wr_addr = r_write_addr;
    w_wr_data = r_inst;
    case (w_state_next)
      ST_WR_A: begin
        w_wr_addr = REG_A;
        w_wr_data = w_accept ? req_a : r_a;
      end
      ST_WR_B: begin
        w_wr_addr = REG_B;
        w_wr_data = w_accept ? req_b : r_b;
      end
      ST_WR_OP: begin
        w_wr_addr = REG_OP;
        w_wr_data = w_accept ? req_op : r_op;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state        <= ST_IDLE;
      r_op           <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_need_b       <= 1'b0;
      r_need_op      <= 1'b0;
      r_write_en     <= 1'b0;
      r_write_addr   <= 3'd0;
      r_inst         <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_zero     <= 1'b0;
      r_rsp_carry    <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_error    <= 1'b0;
      r_op_count     <= '0;
      r_err_count    <= 8'd0;
    end else begin
      r_state      <= w_state_next;
      r_write_en   <= is_write_state(w_state_next);
      r_write_addr <= w_wr_addr;
      r_inst       <= w_wr_data;

      if (w_accept) begin
        r_op      <= req_op;
        r_a       <= req_a;
        r_b       <= req_b;
        r_need_b  <= w_need_b;
        r_need_op <= w_need_op;
      end

      if (r_state == ST_CAPTURE) begin
        r_rsp_valid    <= 1'b1;
        r_rsp_result   <= alu_result;
        r_rsp_zero     <= alu_zero;
        r_rsp_carry    <= alu_carry;
        r_rsp_overflow <= alu_overflow;
        r_rsp_error    <= alu_error;
      end else if (w_pop) begin
        r_rsp_valid <= 1'b0;
      end

      if (w_pop) begin
        r_op_count <= r_op_count + CNT_WIDTH'(1);
        if (r_rsp_error && (r_err_count != 8'hFF))
          r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign req_ready        = w_req_ready;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_result       = r_rsp_result;
  assign rsp_zero         = r_rsp_zero;
  assign rsp_carry        = r_rsp_carry;
  assign rsp_overflow     = r_rsp_overflow;
  assign rsp_error        = r_rsp_error;
  assign alu_writeEn      = r_write_en;
  assign alu_writeAddress = r_write_addr;
  assign alu_inst         = r_inst;
  assign busy             = (r_state != ST_IDLE);
  assign op_count         = r_op_count;
  assign err_count        = r_err_count;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed scoreboard bench for alu_issue_sequencer with a behavioural ALU
// register file behind the write port.
module tb_alu_issue_sequencer;
  import alu_issue_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_op = 8'h0;
  logic [7:0]  req_a = 8'h0;
  logic [7:0]  req_b = 8'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_result;
  logic        rsp_zero, rsp_carry, rsp_overflow, rsp_error;
  logic        alu_writeEn;
  logic [2:0]  alu_writeAddress;
  logic [7:0]  alu_inst;
  logic [7:0]  alu_result;
  logic        alu_zero, alu_carry, alu_overflow, alu_error;
  logic        busy;
  logic [15:0] op_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  alu_issue_sequencer dut (
    .clk              (clk),
    .rstN             (rstN),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_a            (req_a),
    .req_b            (req_b),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_zero         (rsp_zero),
    .rsp_carry        (rsp_carry),
    .rsp_overflow     (rsp_overflow),
    .rsp_error        (rsp_error),
    .alu_writeEn      (alu_writeEn),
    .alu_writeAddress (alu_writeAddress),
    .alu_inst         (alu_inst),
    .alu_result       (alu_result),
    .alu_zero         (alu_zero),
    .alu_carry        (alu_carry),
    .alu_overflow     (alu_overflow),
    .alu_error        (alu_error),
    .busy             (busy),
    .op_count         (op_count),
    .err_count        (err_count)
  );

  // Behavioural ALU: register file written by the DUT, combinational result.
  logic [7:0] m_reg [3] = '{default: 8'h00};
  logic [8:0] m_sum;

  always @(posedge clk)
    if (alu_writeEn && (alu_writeAddress < 3'd3))
      m_reg[alu_writeAddress] <= alu_inst;

  always_comb begin
    m_sum        = 9'd0;
    alu_result   = 8'd0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_error    = 1'b0;
    case (m_reg[0])
      OP_ADD: begin
        m_sum        = {1'b0, m_reg[1]} + {1'b0, m_reg[2]};
        alu_result   = m_sum[7:0];
        alu_carry    = m_sum[8];
        alu_overflow = (m_reg[1][7] == m_reg[2][7]) && (m_sum[7] != m_reg[1][7]);
      end
      OP_SUB: begin
        m_sum        = {1'b0, m_reg[1]} - {1'b0, m_reg[2]};
        alu_result   = m_sum[7:0];
        alu_carry    = m_sum[8];
        alu_overflow = (m_reg[1][7] != m_reg[2][7]) && (m_sum[7] != m_reg[1][7]);
      end
      OP_DIVIDE: begin
        if (m_reg[2] == 8'd0)
          alu_error = 1'b1;
        else
          alu_result = m_reg[1] / m_reg[2];
      end
      default: alu_error = 1'b1;
    endcase
    alu_zero = (alu_result == 8'd0);
  end

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
    logic       e;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] wr_log[$];
  int          checks = 0;
  int          errors = 0;

  function automatic exp_t mk(input logic [7:0] res, input logic z, input logic c,
                              input logic v, input logic e);
    exp_t t;
    t.res = res; t.z = z; t.c = c; t.v = v; t.e = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
    end
  endtask

  // Response monitor: pops the scoreboard whenever a handshake is pending.
  always @(negedge clk) begin
    if (rstN && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", 32'({rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_error}),
            32'(e));
      end
    end
  end

  always @(negedge clk)
    if (alu_writeEn)
      wr_log.push_back({alu_writeAddress, alu_inst});

  task automatic issue(input string name, input logic [7:0] op, input logic [7:0] a,
                       input logic [7:0] b, input exp_t e, input int k,
                       input logic [10:0] w0, input logic [10:0] w1, input logic [10:0] w2);
    int n;
    int lat;
    logic [10:0] ew [3];
    ew[0] = w0; ew[1] = w1; ew[2] = w2;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk({name, "_accept"}, 32'(req_ready), 32'd1);
    wr_log.delete();
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 8'hEE; req_a = 8'hEE; req_b = 8'hEE;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({name, "_latency"}, 32'(lat), 32'(k + 1));
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_nwrites"}, 32'(wr_log.size()), 32'(k));
    for (int i = 0; i < k; i++)
      if (i < wr_log.size())
        chk({name, "_write"}, 32'(wr_log[i]), 32'(ew[i]));
    $display("txn %s op=%0h a=%0d b=%0d lat=%0d writes=%0d", name, op, a, b, lat,
             wr_log.size());
  endtask

  initial begin
    exp_t e5;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_write", 32'({alu_writeEn, alu_writeAddress, alu_inst}), 32'd0);
    chk("rst_rsp_data", 32'({rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_error}), 32'd0);
    chk("rst_counts", 32'({op_count, err_count}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rstN = 1'b1;

    issue("add_full", OP_ADD, 8'd200, 8'd100, mk(8'd44, 0, 1, 0, 0), 3,
          {3'd1, 8'd200}, {3'd2, 8'd100}, {3'd0, OP_ADD});
    issue("add_repeat", OP_ADD, 8'd200, 8'd100, mk(8'd44, 0, 1, 0, 0), 0,
          11'd0, 11'd0, 11'd0);
    chk("op_count_2", 32'(op_count), 32'd2);
    issue("sub_partial", OP_SUB, 8'd200, 8'd50, mk(8'd150, 0, 0, 0, 0), 2,
          {3'd2, 8'd50}, {3'd0, OP_SUB}, 11'd0);
    issue("add_ovf", OP_ADD, 8'd100, 8'd100, mk(8'd200, 0, 0, 1, 0), 3,
          {3'd1, 8'd100}, {3'd2, 8'd100}, {3'd0, OP_ADD});
    issue("add_wrap", OP_ADD, 8'd128, 8'd128, mk(8'd0, 1, 1, 1, 0), 2,
          {3'd1, 8'd128}, {3'd2, 8'd128}, 11'd0);
    issue("div_zero", OP_DIVIDE, 8'd9, 8'd0, mk(8'd0, 1, 0, 0, 1), 3,
          {3'd1, 8'd9}, {3'd2, 8'd0}, {3'd0, OP_DIVIDE});
    chk("err_count_1", 32'(err_count), 32'd1);
    for (int i = 0; i < 256; i++)
      issue("div_rep", OP_DIVIDE, 8'd9, 8'd0, mk(8'd0, 1, 0, 0, 1), 0,
            11'd0, 11'd0, 11'd0);
    chk("err_count_sat", 32'(err_count), 32'd255);
    chk("op_count_262", 32'(op_count), 32'd262);

    // Backpressure, then accept and pop on the same edge
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    e5 = mk(8'd7, 0, 0, 0, 0);
    exp_q.push_back(e5);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SUB; req_a = 8'd10; req_b = 8'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'({rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_error}),
          32'(e5));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("hold_not_popped", 32'(exp_q.size()), 32'd1);
    exp_q.push_back(mk(8'd3, 0, 0, 0, 0));
    req_valid = 1'b1; req_op = OP_ADD; req_a = 8'd1; req_b = 8'd2;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_op_count", 32'(op_count), 32'd263);
    chk("b2b_rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("b2b_first_write", 32'({alu_writeEn, alu_writeAddress, alu_inst}),
        32'({1'b1, 3'd1, 8'd1}));
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);
    chk("op_count_264", 32'(op_count), 32'd264);
    $display("txn backpressure_b2b op=%0h a=1 b=2 cycles=%0d", OP_ADD, n);

    // Reset in the middle of the B write
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD; req_a = 8'd5; req_b = 8'd6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_wr_a", 32'({alu_writeEn, alu_writeAddress}), 32'({1'b1, 3'd1}));
    @(posedge clk); #1;
    chk("mid_wr_b", 32'({alu_writeEn, alu_writeAddress}), 32'({1'b1, 3'd2}));
    rstN = 1'b0;
    #1;
    chk("arst_write_en", 32'(alu_writeEn), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_idle", 32'({busy, req_ready}), 32'({1'b0, 1'b1}));
    chk("arst_op_count", 32'(op_count), 32'd0);
    $display("txn reset_mid_write op=%0h a=5 b=6", OP_ADD);
    @(negedge clk); rstN = 1'b1;
    issue("after_reset", OP_ADD, 8'd5, 8'd6, mk(8'd11, 0, 0, 0, 0), 3,
          {3'd1, 8'd5}, {3'd2, 8'd6}, {3'd0, OP_ADD});
    chk("op_count_after_reset", 32'(op_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
